// File: rtl/snn_egress_pkg.sv
// Shared types for the output spike egress path.
// States, word layout and the EOS marker flag.
package snn_egress_pkg;

  localparam int SPIKE_B     = 8;
  localparam int SPIKE_TS_W  = 8;
  localparam int SPIKE_CNT_W = 8;

  localparam logic EOS_FLAG = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    EOS
  } egress_state_t;

  typedef struct packed {
    logic                  is_eos;
    logic [SPIKE_TS_W-1:0] ts;
    logic [SPIKE_B-1:0]    payload;
  } egress_word_t;

endpackage

// File: rtl/spike_egress_unit.sv
// Pops output spikes, tags them with the timestep, closes steps with EOS.
// Optional EGRESS_PARITY_EN adds out_parity_o (XOR of out_data_o).
module spike_egress_unit
  import snn_egress_pkg::*;
#(
  parameter int B     = SPIKE_B,
  parameter int TS_W  = SPIKE_TS_W,
  parameter int CNT_W = SPIKE_CNT_W
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  input  logic [B-1:0]      fifo_rdata_i,
  input  logic              step_done_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [TS_W+B:0]   out_data_o,
  output logic              busy_o,
  output logic [TS_W-1:0]   ts_o
`ifdef EGRESS_PARITY_EN
  ,output logic             out_parity_o
`endif
);

  localparam int W = 1 + TS_W + B;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  egress_state_t    state_q, state_d;
  logic             eos_pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TS_W-1:0]  ts_q;
  logic             vld_q;
  logic [W-1:0]     data_q;

  logic             hs;
  logic             load;
  logic             spike_acc;
  logic             eos_acc;
  logic [W-1:0]     word_d;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    word_d    = data_q;
    spike_acc = 1'b0;
    eos_acc   = 1'b0;
    hs        = vld_q & out_ready_i;
    unique case (state_q)
      IDLE: begin
        // pops win over EOS so the step drains first
        if (en_i && !fifo_empty_i) begin
          state_d = RD;
        end else if (eos_pend_q) begin
          state_d = EOS;
          load    = 1'b1;
          word_d  = {EOS_FLAG, ts_q, B'(cnt_q)};
        end
      end
      RD: state_d = LAT;
      LAT: begin
        state_d = SEND;
        load    = 1'b1;
        word_d  = {~EOS_FLAG, ts_q, fifo_rdata_i};
      end
      SEND: begin
        if (hs) begin
          state_d   = IDLE;
          spike_acc = 1'b1;
        end
      end
      EOS: begin
        if (hs) begin
          state_d = IDLE;
          eos_acc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      eos_pend_q <= 1'b0;
      cnt_q      <= '0;
      ts_q       <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= word_d;
        vld_q  <= 1'b1;
      end else if (hs) begin
        vld_q  <= 1'b0;
      end
      if (spike_acc && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_W'(1);
      if (eos_acc) begin
        ts_q  <= ts_q + TS_W'(1);
        cnt_q <= '0;
      end
      if (step_done_i)
        eos_pend_q <= 1'b1;
      else if (eos_acc)
        eos_pend_q <= 1'b0;
    end
  end

`ifdef EGRESS_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)
      par_q <= 1'b0;
    else if (load)
      par_q <= ^word_d;
  end

  assign out_parity_o = par_q;
`endif

  assign fifo_rd_o   = (state_q == RD);
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);
  assign ts_o        = ts_q;

endmodule
